// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//  - op codes presented on the CPU-side op port
//  - select codes driven to the alu_1bit slice mux (slice_signal)
//  - FSM state encodings
//  - small helpers that classify an op code
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [2:0] SIG_AND = 3'b000;
  localparam logic [2:0] SIG_OR  = 3'b001;
  localparam logic [2:0] SIG_SUM = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Ops that use the slice adder and therefore report carry/overflow.
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Ops whose slice dataOut is shifted straight into the result.
  function automatic logic op_uses_dout(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // SUB and SLT run the adder with b inverted and carry-in 1.
  function automatic logic op_inverts_b(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic [2:0] op_to_signal(input logic [2:0] op);
    logic [2:0] sig;
    case (op)
      OP_AND:                 sig = SIG_AND;
      OP_OR:                  sig = SIG_OR;
      OP_ADD, OP_SUB, OP_SLT: sig = SIG_SUM;
      default:                sig = SIG_AND;
    endcase
    return sig;
  endfunction

endpackage

// File: rtl/alu_serial_shreg.sv
// WIDTH-bit load / shift-right register.
// Load has priority over shift. On shift the register moves one place towards
// the LSB and i_sin enters at the MSB.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (clears to 0)
//   i_load         parallel load of i_load_val
//   i_load_val     value to load
//   i_shift        shift right by one
//   i_sin          serial-in bit placed at the MSB on shift
//   o_q            register contents
module alu_serial_shreg #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for one external alu_1bit slice.
// Runs a WIDTH-bit AND/OR/ADD/SUB/SLT one bit per cycle, LSB first, behind a
// start/done handshake. Latency from accept to done is WIDTH+1 cycles.
//
// Build option: define ALU_SERIAL_OVF_EN to add the overflow output and make
// SLT a true signed compare (lt = set_msb ^ overflow). Without it SLT returns
// the raw MSB sum bit, as a plain ripple ALU would.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op, a, b     request; op/a/b sampled when start is accepted (IDLE/DONE)
//   busy                high while bits are being processed
//   done                one-cycle pulse, result/flags valid
//   result, cout, zero  final result and flags, held until the next accept
//   overflow            signed overflow (only with ALU_SERIAL_OVF_EN)
//   slice_*  (out)      operand bits, carry and control for the slice; 0 outside RUN
//   slice_dout/cout/set slice dataOut, carry out and adder sum
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one operand bit per cycle through the slice
// DONE    | result valid, done pulse; start here chains a new op
module alu_serial_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
`ifdef ALU_SERIAL_OVF_EN
  output logic             overflow,
`endif
  output logic [2:0]       slice_signal,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_invertB,
  output logic             slice_cin,
  output logic             slice_less,
  input  logic             slice_dout,
  input  logic             slice_cout,
  input  logic             slice_set
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_zero;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_res_bit;
  logic             w_lt;
  logic             w_res_load;
  logic [WIDTH-1:0] w_res_load_val;
  logic [WIDTH-1:0] w_res_final;
  logic [WIDTH-1:0] w_a_q;
  logic [WIDTH-1:0] w_b_q;
  logic [WIDTH-1:0] w_res_q;
  logic             w_unused_hi;

  assign w_run    = (r_state == ST_RUN);
  assign w_last   = w_run && (r_cnt == LAST_BIT);
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy = w_run;
  assign done = (r_state == ST_DONE);

  // ------------------------------------------------- op, counter, carry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= OP_AND;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_op    <= op;
      r_cnt   <= '0;
      r_carry <= op_inverts_b(op);
    end else if (w_run) begin
      r_cnt   <= r_cnt + CW'(1);
      r_carry <= slice_cout;
    end
  end

  // ------------------------------------------------------- slice drive
  assign slice_signal  = w_run ? op_to_signal(r_op) : 3'b000;
  assign slice_a       = w_run & w_a_q[0];
  assign slice_b       = w_run & w_b_q[0];
  assign slice_invertB = w_run & op_inverts_b(r_op);
  assign slice_cin     = w_run & r_carry;
  assign slice_less    = 1'b0;

  // Only the LSBs of the operand shifters reach the slice.
  assign w_unused_hi = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1]};

  // ------------------------------------------------ result and flags
  // Illegal ops shift in zeros so they finish with result 0.
  assign w_res_bit = op_uses_dout(r_op) & slice_dout;

`ifdef ALU_SERIAL_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Carry into the MSB is the carry register while the last bit is processed.
  assign w_ovf = op_is_arith(r_op) & (r_carry ^ slice_cout);
  assign w_lt  = slice_set ^ w_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= w_ovf;
    end
  end

  assign overflow = r_ovf;
`else
  assign w_lt = slice_set;
`endif

  // SLT replaces the shifted result with the compare bit on its last cycle.
  assign w_res_load     = w_last && (r_op == OP_SLT);
  assign w_res_load_val = {{(WIDTH-1){1'b0}}, w_lt};
  assign w_res_final    = w_res_load ? w_res_load_val
                                     : {w_res_bit, w_res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cout <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_last) begin
      r_cout <= op_is_arith(r_op) & slice_cout;
      r_zero <= (w_res_final == '0);
    end
  end

  assign result = w_res_q;
  assign cout   = r_cout;
  assign zero   = r_zero;

  // ------------------------------------------------------ shift registers
  alu_serial_shreg #(.WIDTH(WIDTH)) u_shreg_a (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_accept),
    .i_load_val (a),
    .i_shift    (w_run),
    .i_sin      (1'b0),
    .o_q        (w_a_q)
  );

  alu_serial_shreg #(.WIDTH(WIDTH)) u_shreg_b (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_accept),
    .i_load_val (b),
    .i_shift    (w_run),
    .i_sin      (1'b0),
    .o_q        (w_b_q)
  );

  alu_serial_shreg #(.WIDTH(WIDTH)) u_shreg_res (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_res_load),
    .i_load_val (w_res_load_val),
    .i_shift    (w_run),
    .i_sin      (w_res_bit),
    .o_q        (w_res_q)
  );

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl (WIDTH=32) with a behavioural alu_1bit slice.
// Stimulus pushes expected results into a scoreboard queue; a negedge monitor
// pops and compares whenever done is seen.
module tb_alu_serial_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, cout, zero;
  logic [W-1:0]  result;
  logic [2:0]    slice_signal;
  logic          slice_a, slice_b, slice_invertB, slice_cin, slice_less;
  logic          slice_dout, slice_cout, slice_set;
`ifdef ALU_SERIAL_OVF_EN
  logic          overflow;
`endif

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .cout          (cout),
    .zero          (zero),
`ifdef ALU_SERIAL_OVF_EN
    .overflow      (overflow),
`endif
    .slice_signal  (slice_signal),
    .slice_a       (slice_a),
    .slice_b       (slice_b),
    .slice_invertB (slice_invertB),
    .slice_cin     (slice_cin),
    .slice_less    (slice_less),
    .slice_dout    (slice_dout),
    .slice_cout    (slice_cout),
    .slice_set     (slice_set)
  );

  // Behavioural alu_1bit slice.
  logic bb;
  assign bb         = slice_b ^ slice_invertB;
  assign slice_set  = slice_a ^ bb ^ slice_cin;
  assign slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
  always_comb begin
    slice_dout = slice_less;
    case (slice_signal)
      3'b000:  slice_dout = slice_a & bb;
      3'b001:  slice_dout = slice_a | bb;
      3'b010:  slice_dout = slice_set;
      default: slice_dout = slice_less;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
    int           done_cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, 64'(result), 64'(mon_e.res));
        chk({mon_e.name, "_cout"},   64'(cout),   64'(mon_e.cout));
        chk({mon_e.name, "_zero"},   64'(zero),   64'(mon_e.zero));
        chk({mon_e.name, "_done_cycle"}, 64'(cyc), 64'(mon_e.done_cyc));
`ifdef ALU_SERIAL_OVF_EN
        chk({mon_e.name, "_overflow"}, 64'(overflow), 64'(mon_e.ovf));
`endif
      end
    end
  end

  function automatic exp_t mk(input string nm, input logic [W-1:0] r, input logic c,
                              input logic z, input logic v, input int dc);
    exp_t e;
    e.name = nm; e.res = r; e.cout = c; e.zero = z; e.ovf = v; e.done_cyc = dc;
    return e;
  endfunction

  // Drives one request for one cycle; leaves the bench at the negedge after accept.
  task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] r, input logic c,
                       input logic z, input logic v);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    sb.push_back(mk(nm, r, c, z, v, cyc + W + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * W; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_slice", 64'({slice_signal, slice_a, slice_b, slice_invertB, slice_cin, slice_less}), 64'(0));
`ifdef ALU_SERIAL_OVF_EN
    chk("rst_overflow", 64'(overflow), 64'(0));
`endif
    rst = 1'b0;

    issue("add_wrap", 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
    drain();

    issue("sub_neg", 3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    // Bit 0 in flight: operand LSBs, inverted b, carry-in 1.
    chk("sub_busy", 64'(busy), 64'(1));
    chk("sub_bit0_slice", 64'({slice_signal, slice_a, slice_b, slice_invertB, slice_cin}),
        64'({3'b010, 1'b1, 1'b1, 1'b1, 1'b1}));
    drain();

    issue("and", 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
    drain();
    issue("or", 3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0);
    drain();
    issue("slt_neg", 3'b111, 32'hFFFFFFFD, 32'h00000002, 32'h00000001, 1'b1, 1'b0, 1'b0);
    drain();
`ifdef ALU_SERIAL_OVF_EN
    issue("slt_ovf", 3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b1);
`else
    issue("slt_raw", 3'b111, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
`endif
    drain();
    issue("add_ovf", 3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1);
    drain();
    issue("illegal", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0);
    drain();

    // start pulses while busy must be ignored.
    issue("busy_ign", 3'b010, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    op = 3'b000; a = '0; b = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held through DONE chains a second op.
    @(negedge clk);
    op = 3'b010; a = 32'h00000001; b = 32'h00000002; start = 1'b1;
    sb.push_back(mk("b2b_first", 32'h00000003, 1'b0, 1'b0, 1'b0, cyc + W + 1));
    sb.push_back(mk("b2b_second", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, cyc + 2 * (W + 1)));
    @(negedge clk);
    op = 3'b110; a = 32'h00000000; b = 32'h00000001;
    repeat (W + 1) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-RUN aborts without a done pulse.
    @(negedge clk);
    op = 3'b010; a = 32'h00000003; b = 32'h00000004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_slice", 64'({slice_signal, slice_a, slice_b, slice_invertB, slice_cin, slice_less}), 64'(0));
    rst = 1'b0;
    repeat (W + 8) @(negedge clk);

    issue("post_rst_or", 3'b001, 32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A5FFFF, 1'b0, 1'b0, 1'b0);
    drain();

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
